// File: rtl/quad_encoder_counter.sv
// Quadrature encoder position counter: synchronized, glitch-filtered A/B/I inputs.
// Define QUAD_VELOCITY_EN to include the windowed velocity measurement.
module quad_encoder_counter #(
   parameter int unsigned COUNT_WIDTH  = 24,
   parameter int unsigned FILTER_TICKS = 5,
   parameter int unsigned CLK_FREQ_HZ  = 32_000_000,
   parameter int unsigned VEL_RATE_HZ  = 1000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   quad_a,
   input  logic                   quad_b,
   input  logic                   quad_i,
   input  logic                   index_clear_en,
   input  logic                   error_clear,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [COUNT_WIDTH-1:0] velocity,
   output logic                   velocity_valid,
   output logic                   error
);

   localparam logic [7:0] FILT_LAST = 8'(FILTER_TICKS - 1);

   // Bit order everywhere: [0]=A, [1]=B, [2]=index.
   logic [2:0]      raw;
   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      filt_q, prev_q;
   logic [2:0][7:0] stab_q;

   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   error_q, error_d;
   logic                   step_up, step_dn, illegal;
   logic                   idx_clr;

   assign raw = {quad_i, quad_b, quad_a};

   // During reset every stage tracks the raw pins so release produces no step.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= raw;
         sync2_q <= raw;
         filt_q  <= raw;
         prev_q  <= raw;
         stab_q  <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         prev_q  <= filt_q;
         for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] == filt_q[k]) begin
               stab_q[k] <= 8'd0;
            end else if (stab_q[k] == FILT_LAST) begin
               filt_q[k] <= sync2_q[k];
               stab_q[k] <= 8'd0;
            end else begin
               stab_q[k] <= stab_q[k] + 8'd1;
            end
         end
      end
   end

   // Patterns are {prev A, prev B, cur A, cur B}; forward is 00->10->11->01->00.
   always_comb begin
      step_up = 1'b0;
      step_dn = 1'b0;
      illegal = 1'b0;
      case ({prev_q[0], prev_q[1], filt_q[0], filt_q[1]})
         4'b0010, 4'b1011, 4'b1101, 4'b0100: step_up = 1'b1;
         4'b0001, 4'b0111, 4'b1110, 4'b1000: step_dn = 1'b1;
         4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
         default: ;
      endcase
   end

   assign idx_clr = filt_q[2] & ~prev_q[2] & index_clear_en;

   always_comb begin
      count_d = count_q;
      if (idx_clr) begin
         count_d = '0;
      end else if (step_up) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end else if (step_dn) begin
         count_d = count_q - COUNT_WIDTH'(1);
      end
   end

   always_comb begin
      error_d = error_q;
      if (illegal) begin
         error_d = 1'b1;
      end else if (error_clear) begin
         error_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   assign count = count_q;
   assign error = error_q;

`ifdef QUAD_VELOCITY_EN
   localparam int unsigned WINDOW = CLK_FREQ_HZ / VEL_RATE_HZ;
   localparam int unsigned WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

   logic [WIN_W-1:0]       win_q;
   logic [COUNT_WIDTH-1:0] snap_q, snap_d, snap_base;
   logic [COUNT_WIDTH-1:0] vel_q;
   logic                   vvalid_q;
   logic                   win_end;

   assign win_end = (win_q == WIN_LAST);

   // Rebasing the snapshot by the pre-clear count keeps velocity continuous.
   always_comb begin
      snap_base = win_end ? count_q : snap_q;
      snap_d    = idx_clr ? (snap_base - count_q) : snap_base;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_q    <= '0;
         snap_q   <= '0;
         vel_q    <= '0;
         vvalid_q <= 1'b0;
      end else begin
         vvalid_q <= 1'b0;
         snap_q   <= snap_d;
         if (win_end) begin
            win_q    <= '0;
            vel_q    <= count_q - snap_q;
            vvalid_q <= 1'b1;
         end else begin
            win_q <= win_q + WIN_W'(1);
         end
      end
   end

   assign velocity       = vel_q;
   assign velocity_valid = vvalid_q;
`else
   logic unused_cfg;
   assign unused_cfg     = ^{CLK_FREQ_HZ, VEL_RATE_HZ};
   assign velocity       = '0;
   assign velocity_valid = 1'b0;
`endif

endmodule

// File: doc/quad_encoder_counter.md
QUAD_ENCODER_COUNTER -- requirements
Module: quad_encoder_counter

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 24: width of position and velocity registers, 8..32.
REQ-002 SHALL have parameter FILTER_TICKS, default 5: consecutive stable cycles required before a filtered input changes, 1..255.
REQ-003 SHALL have parameter CLK_FREQ_HZ, default 32_000_000: clk frequency.
REQ-004 SHALL have parameter VEL_RATE_HZ, default 1000: velocity sample rate; window = CLK_FREQ_HZ/VEL_RATE_HZ cycles (integer division).
REQ-005 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have ports quad_a, quad_b  input  1 each: asynchronous encoder phases.
REQ-008 SHALL have port quad_i  input  1: asynchronous encoder index.
REQ-009 SHALL have port index_clear_en  input  1: enables position clear on index rising edge.
REQ-010 SHALL have port error_clear  input  1: clears sticky error.
REQ-011 SHALL have port count  output  COUNT_WIDTH: position, two's-complement.
REQ-012 SHALL have port velocity  output  COUNT_WIDTH: signed counts per window.
REQ-013 SHALL have port velocity_valid  output  1: one-cycle pulse on velocity update.
REQ-014 SHALL have port error  output  1: sticky illegal-transition flag.

Function
REQ-015 SHALL pass quad_a, quad_b, quad_i each through a 2-flop synchronizer.
REQ-016 SHALL per input keep a filtered value, updated to the synchronized value only after it has differed for FILTER_TICKS consecutive cycles; any agreement resets that input's stability counter.
REQ-017 SHALL decode filtered {A,B} against the previous cycle's filtered {A,B}: 00->10->11->01->00 = +1, reverse = -1, no change = 0.
REQ-018 SHALL treat simultaneous change of A and B as illegal: count unchanged, error set.
REQ-019 SHALL make count wrap modulo 2^COUNT_WIDTH in both directions.
REQ-020 SHALL give raw-input-change to count-change latency of exactly FILTER_TICKS+3 cycles.
REQ-021 SHALL on filtered quad_i rising edge with index_clear_en=1 set count to 0; clear wins over a step in the same cycle.
REQ-022 SHALL run a window counter 0..window-1; on terminal value set velocity = count - snapshot (modular, signed), snapshot = count, pulse velocity_valid.
REQ-023 SHALL on index clear set snapshot = snapshot - count(pre-clear) so velocity stays continuous across the clear.
REQ-024 SHALL keep error at 1 until error_clear; illegal transition coincident with error_clear leaves error=1.

Reset
REQ-025 SHALL on reset set count=0, velocity=0, velocity_valid=0, error=0, snapshot=0, window and stability counters=0.
REQ-026 SHALL during reset load synchronizer, filtered and previous-state registers directly from current raw inputs so no step or error is generated at reset release; reset asserted >=2 cycles.
REQ-027 SHALL abort partial windows and pending filter counts on reset mid-operation.

Configuration
REQ-028 SHALL with QUAD_VELOCITY_EN defined include window counter, snapshot and velocity logic per REQ-022/023.
REQ-029 SHALL without QUAD_VELOCITY_EN omit that logic; velocity tied 0, velocity_valid tied 0; all other behaviour unchanged.

Verification
REQ-030 SHALL cover forward: defaults, 4 full forward cycles -> count=16; first change visible 8 cycles after raw edge.
REQ-031 SHALL cover glitch: 4-cycle pulse on quad_a, FILTER_TICKS=5 -> count unchanged, error=0.
REQ-032 SHALL cover wrap: from count=0, one reverse step -> count=0xFFFFFF; then one forward step -> 0.
REQ-033 SHALL cover illegal: filtered 00->11 -> error=1, count unchanged; error_clear pulse -> error=0.
REQ-034 SHALL cover index: count=100, index_clear_en=1, quad_i rise coincident with forward step -> count=0.
REQ-035 SHALL cover velocity: CLK_FREQ_HZ=1000, VEL_RATE_HZ=10, 37 forward steps within one window -> velocity=37 with one-cycle velocity_valid; reverse 5 in next window -> velocity=-5 (0xFFFFFB).
